// File: rtl/riscv_pkg.sv
// Shared RV32 constants and the fetch buffer entry type.
// Used by the fetch unit and its instruction buffer.
package riscv_pkg;

    localparam int unsigned     XLEN             = 32;
    localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    // Sequential fetch step; wraps naturally at the top of the address space.
    function automatic logic [XLEN-1:0] next_pc(input logic [XLEN-1:0] pc);
        return pc + XLEN'(4);
    endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Small circular FIFO of {pc, instr} pairs between instruction memory and IF/ID.
// Flush wins over push/pop; a push into a full buffer is accepted only alongside a pop.
module fetch_buffer
    import riscv_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [XLEN-1:0]            push_pc,
    input  logic [XLEN-1:0]            push_instr,
    input  logic                       pop,
    input  logic                       flush,
    output logic [XLEN-1:0]            head_pc,
    output logic [XLEN-1:0]            head_instr,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty,
    output logic                       full
);

    localparam int unsigned     PtrW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned     CntW    = $clog2(DEPTH + 1);
    localparam logic [PtrW-1:0] LastIdx = PtrW'(DEPTH - 1);

    fetch_entry_t    mem_q [DEPTH];
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic            do_push, do_pop;

    assign empty      = (count_q == '0);
    assign full       = (count_q == CntW'(DEPTH));
    assign count      = count_q;
    assign head_pc    = mem_q[rd_ptr_q].pc;
    assign head_instr = mem_q[rd_ptr_q].instr;

    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_pop) begin
                rd_ptr_d = (rd_ptr_q == LastIdx) ? '0 : rd_ptr_q + 1'b1;
            end
            if (do_push) begin
                wr_ptr_d = (wr_ptr_q == LastIdx) ? '0 : wr_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            if (do_push && !flush) begin
                mem_q[wr_ptr_q] <= '{pc: push_pc, instr: push_instr};
            end
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Credit-based instruction fetch front end feeding the IF/ID register.
// Tracks request PCs in order, buffers early responses and discards stale ones after redirects.
module fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter int unsigned     BUF_DEPTH = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            IFWrite,
    input  logic            Branch,
    input  logic            Jump,
    input  logic [XLEN-1:0] JumpAddr,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic [XLEN-1:0] Instruction_id,
    output logic [XLEN-1:0] PC_id,
    output logic            Valid_id
);

    localparam int unsigned     CntW        = $clog2(BUF_DEPTH + 1);
    localparam int unsigned     PtrW        = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam logic [PtrW-1:0] LastTag     = PtrW'(BUF_DEPTH - 1);
    localparam logic [CntW:0]   CreditLimit = (CntW + 1)'(BUF_DEPTH);

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [CntW-1:0] outstanding_q, outstanding_d;
    logic [CntW-1:0] discard_q, discard_d;
    logic [XLEN-1:0] tag_q [BUF_DEPTH];
    logic [PtrW-1:0] tag_wr_q, tag_wr_d;
    logic [PtrW-1:0] tag_rd_q, tag_rd_d;
    logic [XLEN-1:0] instr_id_q, instr_id_d;
    logic [XLEN-1:0] pc_id_q, pc_id_d;
    logic            valid_id_q, valid_id_d;

    logic            redirect;
    logic            credit_ok;
    logic            accept;
    logic            resp_drop;
    logic            resp_keep;
    logic            advance;
    logic            bypass;
    logic            buf_push;
    logic            buf_pop;
    logic            buf_empty;
    logic            buf_full;
    logic [CntW-1:0] buf_count;
    logic [XLEN-1:0] buf_head_pc;
    logic [XLEN-1:0] buf_head_instr;
    logic [XLEN-1:0] resp_pc;

    assign redirect = (Branch | Jump) & IFWrite;

    // Every in-flight request owns a buffer slot, so responses always have room to land.
    assign credit_ok = ({1'b0, outstanding_q} + {1'b0, buf_count}) < CreditLimit;
    assign imem_req  = ~reset & ~redirect & credit_ok;
    assign imem_addr = fetch_pc_q;
    assign accept    = imem_req & imem_ready;

    assign resp_drop = imem_rvalid & (redirect | (discard_q != '0));
    assign resp_keep = imem_rvalid & ~resp_drop;
    assign resp_pc   = tag_q[tag_rd_q];

    assign advance  = IFWrite & ~redirect;
    assign buf_pop  = advance & ~buf_empty;
    assign bypass   = advance & buf_empty & resp_keep;
    assign buf_push = resp_keep & ~bypass & (~buf_full | buf_pop);

    fetch_buffer #(
        .DEPTH (BUF_DEPTH)
    ) u_fetch_buffer (
        .clk        (clk),
        .reset      (reset),
        .push       (buf_push),
        .push_pc    (resp_pc),
        .push_instr (imem_rdata),
        .pop        (buf_pop),
        .flush      (redirect),
        .head_pc    (buf_head_pc),
        .head_instr (buf_head_instr),
        .count      (buf_count),
        .empty      (buf_empty),
        .full       (buf_full)
    );

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        if (redirect) begin
            fetch_pc_d = JumpAddr;
        end else if (accept) begin
            fetch_pc_d = next_pc(fetch_pc_q);
        end
    end

    always_comb begin
        outstanding_d = outstanding_q;
        case ({accept, imem_rvalid})
            2'b10:   outstanding_d = outstanding_q + 1'b1;
            2'b01:   outstanding_d = outstanding_q - 1'b1;
            default: outstanding_d = outstanding_q;
        endcase
    end

    // A redirect never coincides with an acceptance, so what remains in flight is stale.
    always_comb begin
        discard_d = discard_q;
        if (redirect) begin
            discard_d = imem_rvalid ? outstanding_q - 1'b1 : outstanding_q;
        end else if (imem_rvalid && (discard_q != '0)) begin
            discard_d = discard_q - 1'b1;
        end
    end

    always_comb begin
        tag_wr_d = tag_wr_q;
        tag_rd_d = tag_rd_q;
        if (accept) begin
            tag_wr_d = (tag_wr_q == LastTag) ? '0 : tag_wr_q + 1'b1;
        end
        if (imem_rvalid) begin
            tag_rd_d = (tag_rd_q == LastTag) ? '0 : tag_rd_q + 1'b1;
        end
    end

    always_comb begin
        instr_id_d = instr_id_q;
        pc_id_d    = pc_id_q;
        valid_id_d = valid_id_q;
        if (redirect) begin
            instr_id_d = NOP_INSTR;
            valid_id_d = 1'b0;
        end else if (IFWrite) begin
            if (buf_pop) begin
                instr_id_d = buf_head_instr;
                pc_id_d    = buf_head_pc;
                valid_id_d = 1'b1;
            end else if (bypass) begin
                instr_id_d = imem_rdata;
                pc_id_d    = resp_pc;
                valid_id_d = 1'b1;
            end else begin
                instr_id_d = NOP_INSTR;
                valid_id_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_q    <= RESET_PC;
            outstanding_q <= '0;
            discard_q     <= '0;
            tag_wr_q      <= '0;
            tag_rd_q      <= '0;
            instr_id_q    <= NOP_INSTR;
            pc_id_q       <= '0;
            valid_id_q    <= 1'b0;
            for (int i = 0; i < int'(BUF_DEPTH); i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            tag_wr_q      <= tag_wr_d;
            tag_rd_q      <= tag_rd_d;
            instr_id_q    <= instr_id_d;
            pc_id_q       <= pc_id_d;
            valid_id_q    <= valid_id_d;
            if (accept) begin
                tag_q[tag_wr_q] <= fetch_pc_q;
            end
        end
    end

    assign Instruction_id = instr_id_q;
    assign PC_id          = pc_id_q;
    assign Valid_id       = valid_id_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit against an in-order stream scoreboard and memory model.
// The model tracks epochs, available instructions and the expected program-order PC stream.
module tb_fetch_unit;
    import riscv_pkg::*;

    localparam int Depth = 2;

    logic        clk;
    logic        reset;
    logic        IFWrite;
    logic        Branch;
    logic        Jump;
    logic [31:0] JumpAddr;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] Instruction_id;
    logic [31:0] PC_id;
    logic        Valid_id;

    fetch_unit #(
        .RESET_PC  (32'h0000_0000),
        .BUF_DEPTH (Depth)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .IFWrite        (IFWrite),
        .Branch         (Branch),
        .Jump           (Jump),
        .JumpAddr       (JumpAddr),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ready     (imem_ready),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .Instruction_id (Instruction_id),
        .PC_id          (PC_id),
        .Valid_id       (Valid_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          epoch;
        int          due;
    } mreq_t;

    mreq_t       mq[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    int          epoch = 0;
    int          avail = 0;
    int          lat_lo = 1;
    int          lat_hi = 1;
    int          last_due = 0;
    logic [31:0] scramble = 32'h0;
    logic [31:0] fetch_exp;
    logic [31:0] exp_pc;
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic        m_valid;
    bit          stall_pend = 0;
    logic        obs_req;
    logic [31:0] obs_addr;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ scramble;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic check_ifid();
        check_eq("pc_id", PC_id, m_pc);
        check_eq("instruction_id", Instruction_id, m_instr);
        check_eq("valid_id", {31'b0, Valid_id}, {31'b0, m_valid});
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        IFWrite     = 1'b1;
        Branch      = 1'b0;
        Jump        = 1'b1;
        JumpAddr    = 32'h0000_0400;
        imem_ready  = 1'b1;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD_BEEF;
        #1;
        check_eq("req_in_reset", {31'b0, imem_req}, 32'h0);
        @(posedge clk);
        #1;
        cyc++;
        check_eq("reset_instr", Instruction_id, NOP_INSTR);
        check_eq("reset_valid", {31'b0, Valid_id}, 32'h0);
        check_eq("reset_pc_id", PC_id, 32'h0);
        check_eq("req_in_reset", {31'b0, imem_req}, 32'h0);
        mq.delete();
        epoch      = 0;
        avail      = 0;
        last_due   = 0;
        stall_pend = 0;
        fetch_exp  = 32'h0;
        exp_pc     = 32'h0;
        m_pc       = 32'h0;
        m_instr    = NOP_INSTR;
        m_valid    = 1'b0;
        reset       = 1'b0;
        Jump        = 1'b0;
        imem_rvalid = 1'b0;
        #1;
        check_eq("first_req", {31'b0, imem_req}, 32'h1);
        check_eq("first_addr", imem_addr, 32'h0);
    endtask

    task automatic run_cycle(input logic ifw, input logic br, input logic jp,
                             input logic [31:0] ja, input logic rdy, input bit tput);
        logic  redir;
        logic  rv;
        logic  kept;
        logic  acc;
        mreq_t e;
        IFWrite    = ifw;
        Branch     = br;
        Jump       = jp;
        JumpAddr   = ja;
        imem_ready = rdy;
        rv         = 1'b0;
        kept       = 1'b0;
        imem_rdata = 32'h0;
        if (mq.size() > 0) begin
            if (mq[0].due <= cyc) begin
                rv         = 1'b1;
                imem_rdata = mem_word(mq[0].addr);
                if (mq[0].epoch == epoch) kept = 1'b1;
            end
        end
        imem_rvalid = rv;
        #1;
        redir    = (br | jp) & ifw;
        obs_req  = imem_req;
        obs_addr = imem_addr;
        if (redir) kept = 1'b0;
        if (redir) check_eq("req_on_redirect", {31'b0, obs_req}, 32'h0);
        if (stall_pend && !redir) check_eq("req_held", {31'b0, obs_req}, 32'h1);
        if (obs_req) begin
            check_eq("fetch_addr", obs_addr, fetch_exp);
            check_eq("credit_free", {31'b0, (mq.size() + avail) < Depth}, 32'h1);
        end
        acc        = obs_req & rdy;
        stall_pend = obs_req & ~rdy;
        if (acc) begin
            e.addr  = obs_addr;
            e.epoch = epoch;
            e.due   = cyc + $urandom_range(lat_hi, lat_lo);
            if (e.due <= last_due) e.due = last_due + 1;
            last_due = e.due;
        end
        @(posedge clk);
        #1;
        cyc++;
        if (rv) void'(mq.pop_front());
        if (acc) begin
            mq.push_back(e);
            fetch_exp = fetch_exp + 32'd4;
        end
        if (redir) begin
            epoch++;
            fetch_exp = ja;
            exp_pc    = ja;
            avail     = 0;
            m_instr   = NOP_INSTR;
            m_valid   = 1'b0;
        end else if (ifw) begin
            if (avail + int'(kept) > 0) begin
                m_pc    = exp_pc;
                m_instr = mem_word(exp_pc);
                m_valid = 1'b1;
                exp_pc  = exp_pc + 32'd4;
                avail   = avail + int'(kept) - 1;
            end else begin
                m_instr = NOP_INSTR;
                m_valid = 1'b0;
            end
        end else begin
            avail = avail + int'(kept);
        end
        if (tput) check_eq("throughput", {31'b0, Valid_id}, 32'h1);
        check_ifid();
        check_eq("credit_limit", {31'b0, (mq.size() + avail) <= Depth}, 32'h1);
    endtask

    initial begin
        int  bubbles;
        bit  found;
        reset = 1'b1;
        do_reset();

        // Sequential stream with 1-cycle memory.
        for (int k = 0; k < 4; k++) run_cycle(1, 0, 0, 32'h0, 1, k >= 1);
        check_eq("stream_at_8", PC_id, 32'h8);

        // Load-use stall while 0x8 sits in IF/ID.
        run_cycle(0, 0, 0, 32'h0, 1, 0);
        run_cycle(0, 0, 0, 32'h0, 1, 0);
        check_eq("stall_hold_pc", PC_id, 32'h8);
        run_cycle(1, 0, 0, 32'h0, 1, 1);
        check_eq("after_stall", PC_id, 32'hC);
        for (int k = 0; k < 3; k++) run_cycle(1, 0, 0, 32'h0, 1, 1);

        // Branch with IFWrite=0 must not redirect.
        run_cycle(0, 1, 0, 32'h200, 1, 0);
        check_eq("branch_ignored", {31'b0, imem_addr == 32'h200}, 32'h0);
        for (int k = 0; k < 4; k++) run_cycle(1, 0, 0, 32'h0, 1, 0);

        // Jump with two requests outstanding.
        lat_lo = 3;
        lat_hi = 3;
        for (int k = 0; k < 12 && mq.size() != 2; k++) run_cycle(1, 0, 0, 32'h0, 1, 0);
        check_eq("two_outstanding", mq.size(), 32'd2);
        run_cycle(1, 0, 1, 32'h100, 1, 0);
        check_eq("jump_nop", Instruction_id, NOP_INSTR);
        found = 0;
        for (int k = 0; k < 30 && !found; k++) begin
            run_cycle(1, 0, 0, 32'h0, 1, 0);
            found = Valid_id;
        end
        check_eq("jump_target", PC_id, 32'h100);

        // Fetch PC wraps past the top of the address space.
        lat_lo = 1;
        lat_hi = 1;
        for (int k = 0; k < 5; k++) run_cycle(1, 0, 0, 32'h0, 1, 0);
        run_cycle(1, 1, 0, 32'hFFFF_FFF8, 1, 0);
        found = 0;
        for (int k = 0; k < 15 && !found; k++) begin
            run_cycle(1, 0, 0, 32'h0, 1, 0);
            found = Valid_id && (PC_id == 32'h0);
        end
        check_eq("pc_wrap", {31'b0, found}, 32'h1);

        // Memory back-pressure at 0x10.
        do_reset();
        for (int k = 0; k < 8 && fetch_exp != 32'h10; k++) run_cycle(1, 0, 0, 32'h0, 1, 0);
        check_eq("reach_0x10", imem_addr, 32'h10);
        bubbles = 0;
        for (int k = 0; k < 3; k++) begin
            run_cycle(1, 0, 0, 32'h0, 0, 0);
            check_eq("stall_req", {31'b0, obs_req}, 32'h1);
            check_eq("stall_addr", obs_addr, 32'h10);
            if (!Valid_id) bubbles++;
        end
        check_eq("bubble_seen", {31'b0, bubbles > 0}, 32'h1);
        for (int k = 0; k < 4; k++) run_cycle(1, 0, 0, 32'h0, 1, 0);

        // Mid-stream reset, then randomized traffic with a scrambled memory image.
        scramble = 32'h5A5A_0000;
        do_reset();
        lat_lo = 1;
        lat_hi = 3;
        for (int n = 0; n < 3000; n++) begin
            logic        ifw;
            logic        br;
            logic        jp;
            logic        rdy;
            logic [31:0] ja;
            if ($urandom_range(0, 499) == 0) begin
                do_reset();
            end else begin
                ifw = ($urandom_range(0, 9) < 8);
                br  = ($urandom_range(0, 19) == 0);
                jp  = ($urandom_range(0, 29) == 0);
                rdy = ($urandom_range(0, 3) != 0);
                if ($urandom_range(0, 3) == 0) ja = 32'hFFFF_FFF0 + 32'($urandom_range(0, 3) * 4);
                else ja = $urandom & 32'h0000_FFFC;
                run_cycle(ifw, br, jp, ja, rdy, 0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 Parameter BUF_DEPTH, default 2, instruction buffer entries; it is also the credit limit.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 IFWrite  input  1  1 = IF/ID register may advance; 0 = hold PC_id/Instruction_id (load-use stall).
REQ-006 Branch  input  1  taken conditional branch resolved in ID this cycle.
REQ-007 Jump  input  1  JAL/JALR resolved in ID this cycle.
REQ-008 JumpAddr  input  32  redirect target for Branch or Jump.
REQ-009 imem_req  output  1  fetch request valid.
REQ-010 imem_addr  output  32  fetch byte address, word aligned.
REQ-011 imem_ready  input  1  memory accepts the request when imem_req & imem_ready.
REQ-012 imem_rvalid  input  1  read data valid; responses are in order, at least 1 cycle after acceptance.
REQ-013 imem_rdata  input  32  instruction word.
REQ-014 Instruction_id  output  32  IF/ID instruction register.
REQ-015 PC_id  output  32  IF/ID PC register.
REQ-016 Valid_id  output  1  1 = Instruction_id holds a real fetched instruction.

Function
REQ-017 Redirect SHALL be (Branch | Jump) & IFWrite; Branch/Jump with IFWrite=0 SHALL be ignored.
REQ-018 Credits: outstanding (accepted, not yet returned) plus buffer count SHALL never exceed BUF_DEPTH; imem_req SHALL be 0 when credits are exhausted or redirect=1.
REQ-019 While imem_req=1 and imem_ready=0, imem_addr SHALL stay stable and imem_req SHALL stay 1 unless redirect occurs.
REQ-020 On request acceptance, fetch PC SHALL increment by 4 with 32-bit wrap-around (0xFFFF_FFFC -> 0x0).
REQ-021 Each request's PC SHALL be tracked in order so that every returned word is paired with its PC.
REQ-022 A non-discarded response SHALL push {PC, rdata} into the buffer, except as required by REQ-023.
REQ-023 When IFWrite=1, no redirect, and the buffer is empty, a same-cycle response SHALL bypass the buffer into IF/ID.
REQ-024 When IFWrite=1 with no redirect, IF/ID SHALL load the buffer head (Valid_id=1) and pop it; with nothing available it SHALL load NOP 32'h0000_0013 with Valid_id=0, and PC_id unchanged.
REQ-025 When IFWrite=0, IF/ID and the buffer head SHALL hold; responses SHALL still be accepted into free buffer entries (guaranteed by credits).
REQ-026 On redirect at edge N:
- IF/ID SHALL load NOP with Valid_id=0.
- The buffer SHALL be flushed.
- The discard counter SHALL be loaded with responses still outstanding after this cycle's return; a response returning in cycle N SHALL be dropped.
- Fetch PC SHALL be set to JumpAddr.
REQ-027 While the discard counter is nonzero, each imem_rvalid SHALL be dropped and SHALL decrement the counter; fetches to the new PC MAY issue meanwhile.
REQ-028 Steady-state throughput with 1-cycle memory latency and imem_ready=1 SHALL be one Valid_id instruction per cycle.

Reset
REQ-029 Under reset, the block SHALL clear all state:
- fetch PC = RESET_PC;
- buffer empty, outstanding = 0, discard = 0;
- imem_req = 0;
- Instruction_id = 32'h0000_0013, PC_id = 0, Valid_id = 0.
REQ-030 Reset SHALL override IFWrite, Branch, Jump and imem_rvalid in the same cycle; instruction memory shares this reset, so no pre-reset responses arrive afterwards.
REQ-031 The first request SHALL issue in the first cycle after reset deasserts.

Structure
REQ-032 Shared package riscv_pkg SHALL hold XLEN=32, NOP_INSTR=32'h0000_0013 and the default RESET_PC.
REQ-033 Sub-module fetch_buffer SHALL be a BUF_DEPTH-entry FIFO of {pc, instr} with push, pop, flush, count, empty and full.

Verification
REQ-034 Reset, 1-cycle memory, mem[a]=a:
- imem_addr is 0x0 in the first post-reset cycle.
- PC_id/Instruction_id run 0x0, 0x4, 0x8, one per cycle, Valid_id=1.
REQ-035 IFWrite=0 for 2 cycles while PC_id=0x8:
- PC_id and Instruction_id hold 0x8.
- Outstanding plus buffered never exceeds 2.
- 0xC follows on the first cycle after release.
REQ-036 Jump=1, JumpAddr=0x100 with 2 requests outstanding:
- Next IF/ID is NOP with Valid_id=0.
- Both stale responses are dropped.
- The next Valid_id=1 has PC_id=0x100.
REQ-037 Branch=1 with IFWrite=0, JumpAddr=0x200: no redirect; the sequential stream continues.
REQ-038 imem_ready=0 for 3 cycles at addr 0x10: imem_req=1 and imem_addr=0x10 are stable; NOP bubbles reach IF/ID once the buffer drains.
REQ-039 reset asserted mid-stream: next cycle Instruction_id=0x13, Valid_id=0, PC_id=0, imem_req=0; refetch starts at RESET_PC.
